// File: rtl/mips_regfile_write_arbiter.sv
// mips_regfile_write_arbiter
// Two write-back requesters (0: ALU, 1: load) share the single register-file
// write port. Each requester owns a one-entry buffer; an age-then-round-robin
// arbiter drains the buffers into registered write-port outputs. A busy mask
// of in-flight destination registers is exported for decode-stage stalling.

// One-entry write-back buffer with valid/ready handshake.
module mips_wb_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              in_ready,
  output logic              load,
  output logic              full,
  output logic [ADDR_W-1:0] buf_reg,
  output logic [DATA_W-1:0] buf_data
);

  // A buffer being drained this cycle can reload at the same edge.
  assign in_ready = !rst && (!full || grant);

  // Writes to r0 are accepted but dropped: r0 is hardwired to zero.
  assign load = in_valid && in_ready && (in_reg != '0);

  // Buffer fill/drain; a same-edge reload wins over the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      buf_reg  <= '0;
      buf_data <= '0;
    end else if (load) begin
      full     <= 1'b1;
      buf_reg  <= in_reg;
      buf_data <= in_data;
    end else if (grant) begin
      full     <= 1'b0;
    end
  end

endmodule

module mips_regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       busy_mask
);

  localparam int NREQ = 2;

  logic [NREQ-1:0]             in_valid;
  logic [NREQ-1:0][ADDR_W-1:0] in_reg;
  logic [NREQ-1:0][DATA_W-1:0] in_data;
  logic [NREQ-1:0]             in_ready;
  logic [NREQ-1:0]             load;
  logic [NREQ-1:0]             full;
  logic [NREQ-1:0][ADDR_W-1:0] buf_reg;
  logic [NREQ-1:0][DATA_W-1:0] buf_data;
  logic [NREQ-1:0]             grant;

  // Age state: tie_q = both buffers loaded on the same edge; older_q = index
  // of the buffer loaded first when they were not. Only meaningful while
  // both buffers are full.
  logic tie_q;
  logic older_q;
  logic last_grant_q;
  logic any_full;
  logic gsel;

  assign in_valid = {req1_valid, req0_valid};
  assign in_reg   = {req1_reg,   req0_reg};
  assign in_data  = {req1_data,  req0_data};

  assign req0_ready = in_ready[0];
  assign req1_ready = in_ready[1];

  for (genvar i = 0; i < NREQ; i++) begin : g_buf
    mips_wb_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_buf (
      .clk      (clk),
      .rst      (reset),
      .in_valid (in_valid[i]),
      .in_reg   (in_reg[i]),
      .in_data  (in_data[i]),
      .grant    (grant[i]),
      .in_ready (in_ready[i]),
      .load     (load[i]),
      .full     (full[i]),
      .buf_reg  (buf_reg[i]),
      .buf_data (buf_data[i])
    );
  end

  // Grant from buffer state only: lone full buffer, else older, else round-robin.
  always_comb begin
    any_full = |full;
    if (&full) gsel = tie_q ? ~last_grant_q : older_q;
    else       gsel = full[1];
    grant    = '0;
    if (any_full) grant[gsel] = 1'b1;
  end

  // Track relative age of the two buffers and the last requester granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tie_q        <= 1'b0;
      older_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (any_full) last_grant_q <= gsel;
      if (&load) begin
        tie_q   <= 1'b1;
      end else if (load[0]) begin
        tie_q   <= 1'b0;
        older_q <= 1'b1;
      end else if (load[1]) begin
        tie_q   <= 1'b0;
        older_q <= 1'b0;
      end
    end
  end

  // Registered write port; index/data hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
    end else if (any_full) begin
      signal_reg_write <= 1'b1;
      write_reg        <= buf_reg[gsel];
      write_data       <= buf_data[gsel];
    end else begin
      signal_reg_write <= 1'b0;
    end
  end

  // Busy mask: destinations sitting in a buffer or on the write port.
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = (full[0] && buf_reg[0] == ADDR_W'(r)) ||
                     (full[1] && buf_reg[1] == ADDR_W'(r)) ||
                     (signal_reg_write && write_reg == ADDR_W'(r));
    end
  end

endmodule
